// File: rtl/sha256_pkg.sv
// Shared SHA-256/224 constants, round helper functions and the core state enum.
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sum0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] sum1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_stream_core_round.sv
// One combinational SHA-256 round; working variables indexed 0=a .. 7=h.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [31:0] vin [8],
  input  logic [31:0] k,
  input  logic [31:0] w,
  output logic [31:0] vout [8]
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1 = vin[7] + sum1(vin[4]) + ch(vin[4], vin[5], vin[6]) + k + w;
    t2 = sum0(vin[0]) + maj(vin[0], vin[1], vin[2]);
    vout[0] = t1 + t2;
    vout[1] = vin[0];
    vout[2] = vin[1];
    vout[3] = vin[2];
    vout[4] = vin[3] + t1;
    vout[5] = vin[4];
    vout[6] = vin[5];
    vout[7] = vin[6];
  end

endmodule

// File: rtl/sha256_stream_core.sv
// Streaming SHA-256/224 compression core with per-message hash chaining.
// state | meaning
// IDLE  | waiting for a block; blk_ready high, digest held
// ROUND | UNROLL rounds per clock over the 16-word schedule window
// FINAL | fold working vars into H and publish the digest
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic         blk_first,
  input  logic         mode_224,
  input  logic [511:0] blk_data,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  localparam int         NROUND_CYC = 64 / UNROLL;
  localparam logic [5:0] LAST_RND   = 6'(64 - UNROLL);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("sha256_stream_core: UNROLL must be 1, 2 or 4 (NROUND_CYC=%0d)", NROUND_CYC);
  end

  state_t      state;
  logic [5:0]  rnd;
  logic        mode_q;
  logic [31:0] win     [16];
  logic [31:0] win_nxt [16];
  logic [31:0] h_q     [8];
  logic [31:0] v_q     [8];
  logic [31:0] h_sum   [8];
  logic [31:0] chain   [UNROLL+1][8];
  logic [31:0] k_w     [UNROLL];

  // Extend the window by UNROLL words, then drop the UNROLL oldest ones.
  always_comb begin
    logic [31:0] ext [16+UNROLL];
    for (int i = 0; i < 16 + UNROLL; i++) ext[i] = '0;
    for (int i = 0; i < 16; i++) ext[i] = win[i];
    for (int j = 0; j < UNROLL; j++)
      ext[16+j] = sig1(ext[14+j]) + ext[9+j] + sig0(ext[1+j]) + ext[j];
    for (int i = 0; i < 16; i++) win_nxt[i] = ext[i+UNROLL];
  end

  always_comb begin
    for (int i = 0; i < 8; i++) h_sum[i] = h_q[i] + v_q[i];
  end

  assign chain[0] = v_q;

  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    localparam logic [5:0] JOFS = 6'(j);
    assign k_w[j] = K_TAB[rnd + JOFS];
    sha256_round u_round (
      .vin  (chain[j]),
      .k    (k_w[j]),
      .w    (win[j]),
      .vout (chain[j+1])
    );
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state        <= IDLE;
      blk_ready    <= 1'b0;
      busy         <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
      mode_q       <= 1'b0;
      rnd          <= '0;
      for (int i = 0; i < 8; i++) begin
        h_q[i] <= IV256[i];
        v_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (blk_valid && blk_ready) begin
            for (int i = 0; i < 16; i++) win[i] <= blk_data[511-32*i -: 32];
            if (blk_first) begin
              mode_q <= mode_224;
              for (int i = 0; i < 8; i++) begin
                h_q[i] <= mode_224 ? IV224[i] : IV256[i];
                v_q[i] <= mode_224 ? IV224[i] : IV256[i];
              end
            end else begin
              for (int i = 0; i < 8; i++) v_q[i] <= h_q[i];
            end
            digest       <= '0;
            digest_valid <= 1'b0;
            rnd          <= '0;
            busy         <= 1'b1;
            blk_ready    <= 1'b0;
            state        <= ROUND;
          end else begin
            blk_ready <= 1'b1;
          end
        end
        ROUND: begin
          v_q <= chain[UNROLL];
          win <= win_nxt;
          rnd <= rnd + 6'(UNROLL);
          if (rnd == LAST_RND) state <= FINAL;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) begin
            h_q[i] <= h_sum[i];
            digest[255-32*i -: 32] <= (mode_q && i == 7) ? 32'h0 : h_sum[i];
          end
          digest_valid <= 1'b1;
          busy         <= 1'b0;
          blk_ready    <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          blk_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Scoreboard bench for sha256_stream_core: known-answer digests, latency, chaining and reset abort.
module tb_sha256_stream_core;

  localparam logic [255:0] D_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_ABC224 =
    {224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7, 32'h0};
  localparam logic [255:0] D_TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001c0};

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         blk_valid = 1'b0, valid2 = 1'b0, valid4 = 1'b0;
  logic         blk_first = 1'b0;
  logic         mode_224 = 1'b0;
  logic [511:0] blk_data = '0;
  logic         blk_ready, ready2, ready4;
  logic [255:0] digest, digest2, digest4;
  logic         digest_valid, dv2, dv4;
  logic         busy, busy2, busy4;

  int errors = 0;
  int checks = 0;
  logic [255:0] exp_q [3][$];

  always #5 clk = ~clk;

  sha256_stream_core #(.UNROLL(1)) dut (
    .clk(clk), .clr(clr), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_first(blk_first), .mode_224(mode_224), .blk_data(blk_data),
    .digest(digest), .digest_valid(digest_valid), .busy(busy));

  sha256_stream_core #(.UNROLL(2)) dut2 (
    .clk(clk), .clr(clr), .blk_valid(valid2), .blk_ready(ready2),
    .blk_first(blk_first), .mode_224(mode_224), .blk_data(blk_data),
    .digest(digest2), .digest_valid(dv2), .busy(busy2));

  sha256_stream_core #(.UNROLL(4)) dut4 (
    .clk(clk), .clr(clr), .blk_valid(valid4), .blk_ready(ready4),
    .blk_first(blk_first), .mode_224(mode_224), .blk_data(blk_data),
    .digest(digest4), .digest_valid(dv4), .busy(busy4));

  // Drives one block to the UNROLL=1 core and pushes its expected digest on the accept edge.
  task automatic send_main(input logic [511:0] data, input logic first, input logic m,
                           input logic [255:0] exp, output bit ok);
    blk_data = data; blk_first = first; mode_224 = m; blk_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (blk_ready) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk); #1;
      exp_q[0].push_back(exp);
    end
    blk_valid = 1'b0;
  endtask

  task automatic wait_dv_main(output int lat);
    lat = -1;
    for (int n = 1; n <= 200 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (digest_valid) lat = n;
    end
  endtask

  task automatic test_reset;
    clr = 1'b0;
    #12;
    checks++; if (digest !== '0) begin errors++; $display("FAIL reset_digest got=%h want=0", digest); end
    checks++; if (digest_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got=%b want=0", digest_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (blk_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", blk_ready); end
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1;
    checks++; if (blk_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release got=%b want=1", blk_ready); end
    checks++; if ({ready2, ready4} !== 2'b11) begin errors++; $display("FAIL ready_unroll got=%b want=11", {ready2, ready4}); end
  endtask

  task automatic test_abc(input logic m, input logic [255:0] exp, input string name);
    bit ok; int lat; logic [255:0] want, held;
    send_main(B_ABC, 1'b1, m, exp, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_accept got=timeout want=accept", name); end
    wait_dv_main(lat);
    checks++; if (lat != 65) begin errors++; $display("FAIL %s_latency got=%0d want=65", name, lat); end
    if (exp_q[0].size() == 0) want = '0; else want = exp_q[0].pop_front();
    checks++; if (digest !== want) begin errors++; $display("FAIL %s_digest got=%h want=%h", name, digest, want); end
    held = digest;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (digest_valid !== 1'b1 || digest !== held || busy !== 1'b0) begin
      errors++; $display("FAIL %s_hold got=dv%b busy%b want=dv1 busy0 stable", name, digest_valid, busy);
    end
  endtask

  task automatic test_backpressure;
    bit first_ok, second_ok; int bp_bad, lat; logic [255:0] want;
    first_ok = 1'b0; second_ok = 1'b0; bp_bad = 0;
    blk_data = B_TWO1; blk_first = 1'b1; mode_224 = 1'b0; blk_valid = 1'b1;
    for (int i = 0; i < 200 && !first_ok; i++) begin
      @(negedge clk);
      if (blk_ready) first_ok = 1'b1;
    end
    @(posedge clk); #1;
    blk_data = B_TWO2; blk_first = 1'b0;
    for (int i = 0; i < 200 && !second_ok; i++) begin
      @(negedge clk);
      if (busy && blk_ready) bp_bad++;
      if (blk_ready) second_ok = 1'b1;
    end
    if (second_ok) begin
      @(posedge clk); #1;
      exp_q[0].push_back(D_TWO);
    end
    blk_valid = 1'b0;
    checks++; if (!(first_ok && second_ok)) begin errors++; $display("FAIL bp_accepts got=%b%b want=11", first_ok, second_ok); end
    checks++; if (bp_bad != 0) begin errors++; $display("FAIL bp_ready_while_busy got=%0d want=0", bp_bad); end
    wait_dv_main(lat);
    checks++; if (lat != 65) begin errors++; $display("FAIL bp_latency got=%0d want=65", lat); end
    if (exp_q[0].size() == 0) want = '0; else want = exp_q[0].pop_front();
    checks++; if (digest !== want) begin errors++; $display("FAIL bp_digest got=%h want=%h", digest, want); end
  endtask

  task automatic test_reset_mid;
    bit ok; int lat; logic [255:0] want;
    send_main(B_ABC, 1'b1, 1'b0, D_ABC, ok);
    repeat (30) @(posedge clk);
    #1 clr = 1'b0;
    exp_q[0].delete();
    #1;
    checks++; if (digest !== '0 || digest_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_clear got=dv%b busy%b digest=%h want=0", digest_valid, busy, digest);
    end
    @(negedge clk); clr = 1'b1;
    send_main(B_ABC, 1'b0, 1'b1, D_ABC, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midreset_accept got=timeout want=accept"); end
    wait_dv_main(lat);
    if (exp_q[0].size() == 0) want = '0; else want = exp_q[0].pop_front();
    checks++; if (digest !== want) begin errors++; $display("FAIL midreset_chain_digest got=%h want=%h", digest, want); end
  endtask

  task automatic test_back_to_back;
    bit ok; int lat; logic [255:0] want;
    send_main(B_ABC, 1'b1, 1'b1, D_ABC224, ok);
    wait_dv_main(lat);
    if (exp_q[0].size() == 0) want = '0; else want = exp_q[0].pop_front();
    checks++; if (digest !== want) begin errors++; $display("FAIL b2b_first_digest got=%h want=%h", digest, want); end
    send_main(B_EMPTY, 1'b1, 1'b0, D_EMPTY, ok);
    checks++; if (!ok || digest_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_dv_drop got=ok%b dv%b busy%b want=ok1 dv0 busy1", ok, digest_valid, busy);
    end
    wait_dv_main(lat);
    checks++; if (lat != 65) begin errors++; $display("FAIL b2b_latency got=%0d want=65", lat); end
    if (exp_q[0].size() == 0) want = '0; else want = exp_q[0].pop_front();
    checks++; if (digest !== want) begin errors++; $display("FAIL b2b_empty_digest got=%h want=%h", digest, want); end
  endtask

  task automatic test_unroll;
    bit ok; int lat2, lat4; logic [255:0] want;
    ok = 1'b0; lat2 = -1; lat4 = -1;
    blk_data = B_EMPTY; blk_first = 1'b1; mode_224 = 1'b0; valid2 = 1'b1; valid4 = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (ready2 && ready4) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk); #1;
      exp_q[1].push_back(D_EMPTY);
      exp_q[2].push_back(D_EMPTY);
    end
    valid2 = 1'b0; valid4 = 1'b0;
    for (int n = 1; n <= 100 && (lat2 < 0 || lat4 < 0); n++) begin
      @(posedge clk); #1;
      if (dv2 && lat2 < 0) lat2 = n;
      if (dv4 && lat4 < 0) lat4 = n;
    end
    checks++; if (lat2 != 33) begin errors++; $display("FAIL unroll2_latency got=%0d want=33", lat2); end
    checks++; if (lat4 != 17) begin errors++; $display("FAIL unroll4_latency got=%0d want=17", lat4); end
    if (exp_q[1].size() == 0) want = '0; else want = exp_q[1].pop_front();
    checks++; if (digest2 !== want) begin errors++; $display("FAIL unroll2_digest got=%h want=%h", digest2, want); end
    if (exp_q[2].size() == 0) want = '0; else want = exp_q[2].pop_front();
    checks++; if (digest4 !== want) begin errors++; $display("FAIL unroll4_digest got=%h want=%h", digest4, want); end
  endtask

  initial begin
    test_reset();
    test_unroll();
    test_abc(1'b0, D_ABC, "abc256");
    test_abc(1'b1, D_ABC224, "abc224");
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    checks++; if (exp_q[0].size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q[0].size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sha256_stream_core.md
Name: sha256_stream_core

Overview:
- Next-generation SHA-256 compression engine: accepts a stream of pre-padded 512-bit blocks over a valid/ready handshake and chains the intermediate hash across blocks, so messages of any length are supported.
- Adds a SHA-224 mode and a parametrised unroll factor, so one, two or four rounds complete per clock.
- Sits between the bus-side message buffer/padder and the digest readout registers in the SHA SoC datapath.

Parameters:
- UNROLL, 1, rounds per clock. Legal values are 1, 2 and 4. Any other value is an elaboration error.
- NROUND_CYC, 64/UNROLL, derived localparam. It is the number of round cycles per block.

Ports:
- clk  in  1  clock
- clr  in  1  asynchronous active-low reset
- blk_valid  in  1  blk_data/blk_first/mode_224 are valid
- blk_ready  out  1  core can accept a block
- blk_first  in  1  1 = first block of a message (load IV); 0 = chain from current H
- mode_224  in  1  1 = SHA-224 IV and truncation; sampled only when blk_first=1
- blk_data  in  512  padded block, W0 in [511:480]
- digest  out  256  final hash; SHA-224 result in [255:32], [31:0]=0
- digest_valid  out  1  digest is valid for the last accepted block
- busy  out  1  block in progress

Behaviour:
- Reset (clr=0, async). The following are cleared:
  - state=IDLE
  - blk_ready=0 during reset, 1 from the first clk edge after release
  - digest=0, digest_valid=0, busy=0
  - H0..H7 = SHA-256 IV
  - latched mode=0
  - schedule window and working vars = 0
- Reset asserted mid-block aborts the computation with no digest produced.
- Handshake: a block is accepted on an edge with blk_valid && blk_ready.
  - blk_ready = (state==IDLE), driven from registered state only.
  - blk_ready has no combinational path from blk_valid.
  - blk_valid while not ready is ignored; the data is not latched.
- State machine IDLE -> ROUND -> FINAL -> IDLE.
  - IDLE:
    - On accept: latch blk_data into a 16-word schedule window.
    - If blk_first, load H and a..h from the IV selected by mode_224, and latch mode.
    - Else load a..h from the current H.
    - Clear digest_valid. Round counter=0. Go to ROUND.
  - ROUND: per clock, apply UNROLL consecutive rounds t..t+UNROLL-1 using K[t] and W[t].
    - W[t] for t>=16 = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mod 2^32.
    - The window shifts by UNROLL words per clock.
    - After NROUND_CYC clocks, go to FINAL.
  - FINAL (1 clock):
    - H[i] <= H[i] + var[i], mod 2^32.
    - digest <= new H, truncated and zero-filled when mode=224.
    - digest_valid <= 1. Go to IDLE.
- Latency: digest_valid rises on the (NROUND_CYC+1)th edge after the accepting edge, i.e. 65/33/17 clocks.
  - Block-to-block throughput is NROUND_CYC+2 clocks.
- digest_valid holds, and digest stays stable, until the next accept edge; both clear on that edge.
- Chaining: blk_first=0 immediately after reset chains from the SHA-256 IV. This is legal and equals starting a SHA-256 message.
- mode_224 is ignored when blk_first=0. The latched mode persists for the whole message.
- busy = (state != IDLE).
- All additions are 32-bit modulo. Carry-save adders are permitted internally; only mod-2^32 results are architectural.

Decomposition:
- sha256_pkg holds:
  - K[0..63] constant table
  - SHA-256 and SHA-224 IV constants
  - functions for sum0, sum1, ch, maj, sig0, sig1
  - state enum (IDLE, ROUND, FINAL)
- Sub-module sha256_round: one combinational round, taking a..h, K and W and returning the next a..h.
  - Instantiated UNROLL times in a generate chain.
  - The schedule window stays in the top level.

Test Plan:
- Single block "abc" (padded), blk_first=1, mode_224=0, UNROLL=1 -> digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. digest_valid rises exactly 65 clocks after accept.
- Same block, mode_224=1 -> digest[255:32]=23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, digest[31:0]=0.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", first block with blk_first=1, second with blk_first=0, blk_valid held high throughout (backpressure) -> blk_ready low while busy, no block lost. digest=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Empty message (block 80000000_00..00), run for UNROLL=1, 2 and 4 -> digest=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855 each time, with latency 65/33/17.
- Reset mid-operation: assert clr=0 at round 30 of "abc". Then:
  - Expect digest=0, digest_valid=0, busy=0 immediately.
  - After release, an "abc" block with blk_first=0 gives the SHA-256 "abc" digest, proving H was restored to the IV.
- Back-to-back messages: "abc" with mode 224, then empty with blk_first=1 and mode_224=0 -> second digest equals the SHA-256 empty hash. digest_valid drops on the second accept edge.
